// File: rtl/flick_debouncer_pkg.sv
// Shared state encoding and default timing constants for the FLICK button debouncer.
package flick_debouncer_pkg;

    typedef enum logic [1:0] {
        FD_IDLE         = 2'b00,
        FD_PRESS_WAIT   = 2'b01,
        FD_PRESSED      = 2'b10,
        FD_RELEASE_WAIT = 2'b11
    } fd_state_t;

    localparam int FD_DEBOUNCE_DEF = 16;
    localparam int FD_REPEAT_DEF   = 64;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; both stages reset to 0.
module sync_2ff (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/flick_debouncer.sv
// Synchronises and debounces the raw FLICK button into a clean level plus a press pulse.
// Optional auto-repeat pulses while held are built only when FLICK_AUTOREPEAT_EN is defined.
module flick_debouncer
    import flick_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = FD_DEBOUNCE_DEF,
    parameter int REPEAT_CYCLES   = FD_REPEAT_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_RAW,
    output logic FLICK,
    output logic FLICK_PULSE,
    output logic BUSY
);

    localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic            w_btn_s;
    fd_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic            r_flick;
    logic            r_pulse;
    logic            r_busy;

    sync_2ff u_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (BTN_RAW),
        .q   (w_btn_s)
    );

`ifdef FLICK_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] r_rpt;

    // Runs only while PRESSED and still held, so any exit (including a bounce) clears it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rpt <= '0;
        end else if (r_state == FD_PRESSED && w_btn_s) begin
            if (r_rpt == RPT_LAST) r_rpt <= '0;
            else                   r_rpt <= r_rpt + 1'b1;
        end else begin
            r_rpt <= '0;
        end
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= FD_IDLE;
            r_cnt   <= '0;
            r_flick <= 1'b0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                FD_IDLE: begin
                    if (w_btn_s) begin
                        r_state <= FD_PRESS_WAIT;
                        r_cnt   <= CNT_W'(1);
                        r_busy  <= 1'b1;
                    end
                end
                FD_PRESS_WAIT: begin
                    if (!w_btn_s) begin
                        r_state <= FD_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == DB_LAST) begin
                        r_state <= FD_PRESSED;
                        r_cnt   <= '0;
                        r_flick <= 1'b1;
                        r_pulse <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                FD_PRESSED: begin
                    if (!w_btn_s) begin
                        r_state <= FD_RELEASE_WAIT;
                        r_cnt   <= CNT_W'(1);
                    end
`ifdef FLICK_AUTOREPEAT_EN
                    else if (r_rpt == RPT_LAST) begin
                        r_pulse <= 1'b1;
                    end
`endif
                end
                FD_RELEASE_WAIT: begin
                    if (w_btn_s) begin
                        r_state <= FD_PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == DB_LAST) begin
                        r_state <= FD_IDLE;
                        r_cnt   <= '0;
                        r_flick <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= FD_IDLE;
                    r_cnt   <= '0;
                    r_flick <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign FLICK       = r_flick;
    assign FLICK_PULSE = r_pulse;
    assign BUSY        = r_busy;

endmodule

// File: tb/tb_flick_debouncer.sv
// Directed bench for flick_debouncer with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
module tb_flick_debouncer;

    logic CLK     = 1'b0;
    logic RST     = 1'b1;
    logic BTN_RAW = 1'b0;
    logic FLICK;
    logic FLICK_PULSE;
    logic BUSY;

    int errors = 0;
    int checks = 0;

`ifdef FLICK_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    int   n_pulse, n_rise, n_fall, n_busy, n_dbl;
    logic prev_f, prev_p;

    always #5 CLK = ~CLK;

    flick_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (8)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .BTN_RAW     (BTN_RAW),
        .FLICK       (FLICK),
        .FLICK_PULSE (FLICK_PULSE),
        .BUSY        (BUSY)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        n_pulse = 0; n_rise = 0; n_fall = 0; n_busy = 0; n_dbl = 0;
        prev_f  = FLICK;
        prev_p  = FLICK_PULSE;
    endtask

    // Drive one raw sample, advance one edge, and accumulate observed events.
    task automatic step(input logic btn);
        BTN_RAW = btn;
        tick();
        if (FLICK_PULSE)           n_pulse++;
        if (FLICK_PULSE && prev_p) n_dbl++;
        if (FLICK && !prev_f)      n_rise++;
        if (!FLICK && prev_f)      n_fall++;
        if (BUSY)                  n_busy++;
        prev_f = FLICK;
        prev_p = FLICK_PULSE;
    endtask

    task automatic steps(input logic btn, input int n);
        for (int i = 0; i < n; i++) step(btn);
    endtask

    int pat[22] = '{1,0,1,0,1,1,1,1,1,1,1,0,1,0,0,0,0,0,0,0,0,0};
    int first_idx;

    initial begin
        // Reset
        repeat (3) tick();
        chk("rst_flick", FLICK, 0);
        chk("rst_pulse", FLICK_PULSE, 0);
        chk("rst_busy", BUSY, 0);
        RST = 1'b0;
        steps(0, 3);
        chk("idle_busy", BUSY, 0);

        // 1: clean press and release
        clr();
        steps(1, 2);
        chk("t1_busy_e2", BUSY, 0);
        step(1);
        chk("t1_busy_e3", BUSY, 1);
        steps(1, 2);
        chk("t1_flick_e5", FLICK, 0);
        chk("t1_pulse_e5", FLICK_PULSE, 0);
        step(1);
        chk("t1_flick_e6", FLICK, 1);
        chk("t1_pulse_e6", FLICK_PULSE, 1);
        step(1);
        chk("t1_pulse_e7", FLICK_PULSE, 0);
        chk("t1_flick_e7", FLICK, 1);
        clr();
        steps(1, 20);
        chk("t1_hold_pulses", n_pulse, AR ? 2 : 0);
        clr();
        steps(0, 5);
        chk("t1_rel_flick_e5", FLICK, 1);
        step(0);
        chk("t1_rel_flick_e6", FLICK, 0);
        chk("t1_rel_pulses", n_pulse, 0);
        chk("t1_rel_busy", BUSY, 0);
        steps(0, 4);

        // 2: short glitch rejected
        clr();
        steps(1, 3);
        steps(0, 9);
        chk("t2_pulses", n_pulse, 0);
        chk("t2_rises", n_rise, 0);
        chk("t2_busy_cycles", n_busy, 3);
        chk("t2_busy_end", BUSY, 0);

        // 3: bounce on release
        clr();
        steps(1, 6);
        chk("t3_flick_on", FLICK, 1);
        step(1);
        step(0); step(0); step(1);
        steps(0, 5);
        chk("t3_flick_b8", FLICK, 1);
        step(0);
        chk("t3_flick_b9", FLICK, 0);
        steps(0, 4);
        chk("t3_pulses", n_pulse, 1);
        chk("t3_falls", n_fall, 1);

        // 4: reset mid-press, button still held at release
        steps(1, 6);
        chk("t4_flick_on", FLICK, 1);
        #2 RST = 1'b1;
        #1;
        chk("t4_rst_flick", FLICK, 0);
        chk("t4_rst_busy", BUSY, 0);
        repeat (2) tick();
        RST = 1'b0;
        clr();
        steps(1, 5);
        chk("t4_pulse_e5", FLICK_PULSE, 0);
        chk("t4_flick_e5", FLICK, 0);
        step(1);
        chk("t4_pulse_e6", FLICK_PULSE, 1);
        chk("t4_flick_e6", FLICK, 1);
        steps(0, 10);

        // 5: hold 30 cycles after acceptance
        steps(1, 6);
        chk("t5_pulse_acc", FLICK_PULSE, 1);
        clr();
        first_idx = 0;
        for (int i = 1; i <= 30; i++) begin
            step(1);
            if (FLICK_PULSE && first_idx == 0) first_idx = i;
        end
        chk("t5_repeat_cnt", n_pulse, AR ? 3 : 0);
        chk("t5_first_repeat", first_idx, AR ? 8 : 0);
        chk("t5_double", n_dbl, 0);
        chk("t5_flick_held", FLICK, 1);
        steps(0, 10);
        chk("t5_flick_off", FLICK, 0);

        // 6: two bouncy press/release cycles
        clr();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 22; i++) step(pat[i][0]);
        chk("t6_rises", n_rise, 2);
        chk("t6_falls", n_fall, 2);
        chk("t6_pulses", n_pulse, 2);
        chk("t6_flick_end", FLICK, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
